// File: rtl/seq_shift_register_pkg.sv
// Shared types and helpers for the multi-cycle shift unit.
// Mode and state encodings, direction constants, and the amt width function.
package seq_shift_register_pkg;

    typedef enum logic [1:0] {SH_LOGIC, SH_SERIAL, SH_ARITH, SH_ROT} shift_mode_e;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} shift_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Bits needed to hold a step count of 0..width.
    function automatic int unsigned amt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_shift_register_if.sv
// Control/data bundle for seq_shift_register.
// master drives load/start/operands; slave (the shifter) returns q and status.
interface seq_shift_register_if
    import seq_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned AW = amt_width(WIDTH);

    logic             load;
    logic [WIDTH-1:0] d;
    logic             start;
    logic             dir;
    logic [1:0]       mode;
    logic [AW-1:0]    amt;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output load, d, start, dir, mode, amt, ser_in,
        input  q, ser_out, busy, done
    );

    modport slave (
        input  load, d, start, dir, mode, amt, ser_in,
        output q, ser_out, busy, done
    );

endinterface

// File: rtl/seq_shift_register_step.sv
// One-position shift of a WIDTH-bit word with an externally chosen fill bit.
// Purely combinational; returns the shifted word and the bit that fell off.
module seq_shift_register_step
    import seq_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] q_next_c,
    output logic             out_c
);

    always_comb begin
        if (dir == DIR_RIGHT) begin
            q_next_c = {fill, q[WIDTH-1:1]};
            out_c    = q[0];
        end else begin
            q_next_c = {q[WIDTH-2:0], fill};
            out_c    = q[WIDTH-1];
        end
    end

endmodule

// File: rtl/seq_shift_register.sv
// Multi-cycle shifter: shifts the held word amt positions, one per clock, with start/busy/done.
// Define SEQ_SHIFT_ROTATE_EN to enable rotate (mode 11, unclamped amt); otherwise mode 11 acts as logical.
module seq_shift_register
    import seq_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_shift_register_if.slave  bus
);

    localparam int unsigned AW = amt_width(WIDTH);

    localparam logic [1:0] IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] SHIFT = 2'(ST_SHIFT);
    localparam logic [1:0] DONE  = 2'(ST_DONE);

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic             so_r, so_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic             dir_r, dir_nxt;
    shift_mode_e      mode_r, mode_nxt;
    shift_mode_e      mode_in;
    logic [AW-1:0]    amt_clamp;
    logic [AW-1:0]    amt_load;
    logic             busy_r, done_r;
    logic             fill;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    // Mode decode at start; without rotate support mode 11 collapses to logical.
    always_comb begin
        amt_clamp = (bus.amt > AW'(WIDTH)) ? AW'(WIDTH) : bus.amt;
`ifdef SEQ_SHIFT_ROTATE_EN
        mode_in  = shift_mode_e'(bus.mode);
        amt_load = (mode_in == SH_ROT) ? bus.amt : amt_clamp;
`else
        mode_in  = (bus.mode == 2'(SH_ROT)) ? SH_LOGIC : shift_mode_e'(bus.mode);
        amt_load = amt_clamp;
`endif
    end

    // Fill bit entering the vacated end on each step.
    always_comb begin
        fill = 1'b0;
        case (mode_r)
            SH_SERIAL: fill = bus.ser_in;
            SH_ARITH:  fill = (dir_r == DIR_RIGHT) ? q_r[WIDTH-1] : 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
            SH_ROT:    fill = (dir_r == DIR_RIGHT) ? q_r[0] : q_r[WIDTH-1];
`endif
            default:   fill = 1'b0;
        endcase
    end

    seq_shift_register_step #(.WIDTH(WIDTH)) u_step (
        .q        (q_r),
        .dir      (dir_r),
        .fill     (fill),
        .q_next_c (step_q),
        .out_c    (step_out)
    );

    // Next-state and datapath update; load beats start in IDLE.
    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        so_nxt    = so_r;
        cnt_nxt   = cnt;
        dir_nxt   = dir_r;
        mode_nxt  = mode_r;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    q_nxt = bus.d;
                end else if (bus.start) begin
                    dir_nxt   = bus.dir;
                    mode_nxt  = mode_in;
                    cnt_nxt   = amt_load;
                    state_nxt = (bus.amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                q_nxt   = step_q;
                so_nxt  = step_out;
                cnt_nxt = cnt - AW'(1);
                if (cnt == AW'(1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q_r    <= '0;
            so_r   <= 1'b0;
            cnt    <= '0;
            dir_r  <= DIR_LEFT;
            mode_r <= SH_LOGIC;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            q_r    <= q_nxt;
            so_r   <= so_nxt;
            cnt    <= cnt_nxt;
            dir_r  <= dir_nxt;
            mode_r <= mode_nxt;
            busy_r <= (state_nxt == SHIFT);
            done_r <= (state_nxt == DONE);
        end
    end

    assign bus.q       = q_r;
    assign bus.ser_out = so_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

endmodule

// File: tb/tb_seq_shift_register.sv
// Scoreboard bench for seq_shift_register at WIDTH=8.
// Expected results come from a bit-level reference model and fixed known answers.
module tb_seq_shift_register;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [7:0] q;
        logic       so;
        logic [4:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [7:0] m_q;
    logic       m_so;

    always #5 clk = ~clk;

    seq_shift_register_if #(.WIDTH(W)) bus ();

    seq_shift_register #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t model(input logic [7:0] q0, input logic so0, input logic dir,
                                   input logic [1:0] mode, input logic [3:0] amt,
                                   input logic [15:0] bits);
        exp_t       e;
        logic [1:0] m = mode;
        int         n = int'(amt);
        logic [7:0] q = q0;
        logic       so = so0;
        logic       o;
        logic       f;
`ifndef SEQ_SHIFT_ROTATE_EN
        if (m == 2'b11) m = 2'b00;
`endif
        if (m != 2'b11 && n > 8) n = 8;
        for (int i = 0; i < n; i++) begin
            o = dir ? q[0] : q[7];
            case (m)
                2'b00:   f = 1'b0;
                2'b01:   f = bits[i];
                2'b10:   f = dir ? q[7] : 1'b0;
                default: f = o;
            endcase
            q  = dir ? {f, q[7:1]} : {q[6:0], f};
            so = o;
        end
        e.q   = q;
        e.so  = so;
        e.cyc = 5'(n);
        return e;
    endfunction

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        bus.load = 1'b1;
        bus.d    = v;
        @(negedge clk);
        bus.load = 1'b0;
        m_q = v;
        n_checks++;
        if (bus.q !== v) begin
            $display("FAIL load q: got %h expected %h", bus.q, v);
            n_fail++;
        end
    endtask

    // Drives one start, feeds ser_in per step, then pops and checks the scoreboard.
    task automatic run_shift(input string name, input logic dir, input logic [1:0] mode,
                             input logic [3:0] amt, input logic [15:0] bits, input bit disturb);
        exp_t e;
        int   nb;
        int   guard;
        e = model(m_q, m_so, dir, mode, amt, bits);
        sb.push_back(e);
        m_q  = e.q;
        m_so = e.so;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dir   = dir;
        bus.mode  = mode;
        bus.amt   = amt;
        @(negedge clk);
        bus.start = 1'b0;
        nb = 0;
        guard = 0;
        while (bus.done !== 1'b1 && guard < 40) begin
            if (bus.busy === 1'b1) begin
                bus.ser_in = bits[nb];
                if (disturb && nb == 2) begin
                    bus.load  = 1'b1;
                    bus.start = 1'b1;
                    bus.d     = 8'h00;
                    bus.amt   = 4'd1;
                end else begin
                    bus.load  = 1'b0;
                    bus.start = 1'b0;
                end
                nb++;
            end
            @(negedge clk);
            guard++;
        end
        bus.load  = 1'b0;
        bus.start = 1'b0;
        n_checks++;
        if (guard >= 40) begin
            $display("FAIL %s timeout: done never seen after %0d cycles", name, guard);
            n_fail++;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.q !== e.q) begin
            $display("FAIL %s q: got %h expected %h", name, bus.q, e.q);
            n_fail++;
        end
        n_checks++;
        if (bus.ser_out !== e.so) begin
            $display("FAIL %s ser_out: got %b expected %b", name, bus.ser_out, e.so);
            n_fail++;
        end
        n_checks++;
        if (nb != int'(e.cyc)) begin
            $display("FAIL %s busy cycles: got %0d expected %0d", name, nb, e.cyc);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL %s done pulse: done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.q !== 8'h00 || bus.ser_out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL reset: q=%h so=%b busy=%b done=%b expected 00 0 0 0",
                     bus.q, bus.ser_out, bus.busy, bus.done);
            n_fail++;
        end
        rst  = 1'b0;
        m_q  = 8'h00;
        m_so = 1'b0;
    endtask

    task automatic test_logical();
        do_load(8'hA5);
        run_shift("logic_left3", 1'b0, 2'b00, 4'd3, 16'h0000, 1'b0);
        n_checks++;
        if (bus.q !== 8'h28 || bus.ser_out !== 1'b1) begin
            $display("FAIL logic_left3 known answer: got %h/%b expected 28/1", bus.q, bus.ser_out);
            n_fail++;
        end
    endtask

    task automatic test_arith();
        do_load(8'h96);
        run_shift("arith_right2", 1'b1, 2'b10, 4'd2, 16'h0000, 1'b0);
        n_checks++;
        if (bus.q !== 8'hE5) begin
            $display("FAIL arith_right2 known answer: got %h expected e5", bus.q);
            n_fail++;
        end
        do_load(8'h81);
        run_shift("arith_left3", 1'b0, 2'b10, 4'd3, 16'h0000, 1'b0);
    endtask

    task automatic test_rotate();
        logic [7:0] exp_q;
`ifdef SEQ_SHIFT_ROTATE_EN
        exp_q = 8'h5A;
`else
        exp_q = 8'h0A;
`endif
        do_load(8'hA5);
        run_shift("rot_right4", 1'b1, 2'b11, 4'd4, 16'h0000, 1'b0);
        n_checks++;
        if (bus.q !== exp_q) begin
            $display("FAIL rot_right4 known answer: got %h expected %h", bus.q, exp_q);
            n_fail++;
        end
        do_load(8'h3C);
        run_shift("rot_left11", 1'b0, 2'b11, 4'd11, 16'h0000, 1'b0);
    endtask

    task automatic test_amt_bounds();
        do_load(8'h5A);
        run_shift("amt0", 1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);
        n_checks++;
        if (bus.q !== 8'h5A) begin
            $display("FAIL amt0 q unchanged: got %h expected 5a", bus.q);
            n_fail++;
        end
        do_load(8'hA5);
        run_shift("amt9_clamp", 1'b0, 2'b00, 4'd9, 16'h0000, 1'b0);
        n_checks++;
        if (bus.q !== 8'h00) begin
            $display("FAIL amt9_clamp known answer: got %h expected 00", bus.q);
            n_fail++;
        end
    endtask

    task automatic test_serial();
        do_load(8'hFF);
        run_shift("serial_left5", 1'b0, 2'b01, 4'd5, 16'b01010, 1'b1);
        n_checks++;
        if (bus.q !== 8'hEA) begin
            $display("FAIL serial_left5 known answer: got %h expected ea", bus.q);
            n_fail++;
        end
    endtask

    task automatic test_load_priority();
        @(negedge clk);
        bus.load  = 1'b1;
        bus.start = 1'b1;
        bus.d     = 8'h3C;
        bus.amt   = 4'd3;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.start = 1'b0;
        m_q = 8'h3C;
        @(negedge clk);
        n_checks++;
        if (bus.q !== 8'h3C || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL load_priority: q=%h busy=%b done=%b expected 3c 0 0",
                     bus.q, bus.busy, bus.done);
            n_fail++;
        end
    endtask

    task automatic test_mid_reset();
        do_load(8'hC3);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dir   = 1'b0;
        bus.mode  = 2'b00;
        bus.amt   = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ser_out !== 1'b0) begin
            $display("FAIL mid_reset: q=%h busy=%b done=%b so=%b expected 00 0 0 0",
                     bus.q, bus.busy, bus.done, bus.ser_out);
            n_fail++;
        end
        rst  = 1'b0;
        m_q  = 8'h00;
        m_so = 1'b0;
        @(negedge clk);
        do_load(8'h81);
        run_shift("after_reset", 1'b1, 2'b00, 4'd1, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        bits = 16'($urandom);
        run_shift("b2b_serial_right", 1'b1, 2'b01, 4'd6, bits, 1'b0);
        run_shift("b2b_arith_right", 1'b1, 2'b10, 4'd3, 16'h0000, 1'b0);
        bits = 16'($urandom);
        run_shift("b2b_serial_left", 1'b0, 2'b01, 4'd8, bits, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.load   = 1'b0;
        bus.d      = '0;
        bus.start  = 1'b0;
        bus.dir    = 1'b0;
        bus.mode   = 2'b00;
        bus.amt    = '0;
        bus.ser_in = 1'b0;
        test_reset();
        test_logical();
        test_arith();
        test_rotate();
        test_amt_bounds();
        test_serial();
        test_load_priority();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
